// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the combinational ROM and
// registers each fetched word into a one-entry valid/ready output stage.
module fetch_sequencer #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int RESET_PC = 0,
   parameter int PROG_LEN = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt_req,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic              busy,
   output logic              halted,
   output logic [15:0]       fetch_count
);

   // Handshake: inst transfers on a cycle where inst_valid && inst_ready; once
   // raised, inst_valid and inst stay stable until that transfer or a flush.

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   // A PROG_LEN that covers the whole address space means the PC simply wraps.
   localparam bit                HAS_END = PROG_LEN < (1 << ADDR_W);
   localparam logic [ADDR_W-1:0] END_PC  = ADDR_W'(PROG_LEN);
   localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);

   state_t              state_q;
   logic [ADDR_W-1:0]   pc_q;
   logic [DATA_W-1:0]   inst_q;
   logic [ADDR_W-1:0]   inst_pc_q;
   logic                inst_valid_q;
   logic                busy_q;
   logic                halted_q;
   logic [15:0]         fetch_count_q;
   logic [15:0]         fetch_count_d;
   logic                handshake;
   logic                can_load;
   logic                at_end;
   logic                in_prog;

   always_comb begin
      handshake     = inst_valid_q && inst_ready;
      can_load      = !inst_valid_q || inst_ready;
      at_end        = HAS_END && (pc_q == END_PC);
      in_prog       = !HAS_END || (pc_q < END_PC);
      fetch_count_d = fetch_count_q;
      if (handshake && (fetch_count_q != 16'hFFFF)) begin
         fetch_count_d = fetch_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= PC_RST;
         inst_q        <= '0;
         inst_pc_q     <= '0;
         inst_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
         halted_q      <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         fetch_count_q <= fetch_count_d;
         // A consumed entry empties unless a load below refills it.
         if (handshake) begin
            inst_valid_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (redirect_valid) begin
                  pc_q <= redirect_pc;
               end
               if (start) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               if (redirect_valid) begin
                  pc_q         <= redirect_pc;
                  inst_valid_q <= 1'b0;
                  if (halt_req) begin
                     state_q  <= S_HALT;
                     busy_q   <= 1'b0;
                     halted_q <= 1'b1;
                  end
               end else if (halt_req || at_end) begin
                  state_q  <= S_HALT;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else if (can_load && in_prog) begin
                  inst_q       <= rom_data;
                  inst_pc_q    <= pc_q;
                  inst_valid_q <= 1'b1;
                  pc_q         <= pc_q + ADDR_W'(1);
               end
            end
            S_HALT: begin
            end
            default: begin
               state_q  <= S_IDLE;
               busy_q   <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign rom_addr    = pc_q;
   assign inst        = inst_q;
   assign inst_pc     = inst_pc_q;
   assign inst_valid  = inst_valid_q;
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a cycle model checked every cycle plus directed
// literal expectations, and a second instance covering PC wrap.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_pc = 8'd0;
   logic [7:0]  rom_addr;
   logic [31:0] rom_data;
   logic [31:0] inst;
   logic [7:0]  inst_pc;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic        busy;
   logic        halted;
   logic [15:0] fetch_count;

   logic        start_b = 1'b0;
   logic        ready_b = 1'b0;
   logic [7:0]  rom_addr_b;
   logic [31:0] rom_data_b;
   logic [31:0] inst_b;
   logic [7:0]  inst_pc_b;
   logic        inst_valid_b;
   logic        busy_b;
   logic        halted_b;
   logic [15:0] fetch_count_b;

   logic [31:0] rom [256];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   initial begin
      rom[0] = 32'h20010003;
      rom[1] = 32'h20020009;
      rom[2] = 32'h00221020;
      rom[3] = 32'h00221824;
      rom[4] = 32'h00222025;
      for (int i = 5; i < 256; i++) rom[i] = 32'hA5000000 | 32'(i);
   end

   assign rom_data   = rom[rom_addr];
   assign rom_data_b = rom[rom_addr_b];

   fetch_sequencer #(.ADDR_W(8), .DATA_W(32), .RESET_PC(0), .PROG_LEN(5)) dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .rom_addr(rom_addr), .rom_data(rom_data), .inst(inst), .inst_pc(inst_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .busy(busy),
      .halted(halted), .fetch_count(fetch_count)
   );

   fetch_sequencer #(.ADDR_W(8), .DATA_W(32), .RESET_PC(254), .PROG_LEN(256)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .halt_req(1'b0),
      .redirect_valid(1'b0), .redirect_pc(8'd0),
      .rom_addr(rom_addr_b), .rom_data(rom_data_b), .inst(inst_b), .inst_pc(inst_pc_b),
      .inst_valid(inst_valid_b), .inst_ready(ready_b), .busy(busy_b),
      .halted(halted_b), .fetch_count(fetch_count_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model of the PROG_LEN=5 instance: phase 0 idle, 1 running, 2 stopped.
   int          m_phase = 0;
   logic [7:0]  m_pc = 8'd0;
   logic [31:0] m_inst = 32'd0;
   logic [7:0]  m_ipc = 8'd0;
   bit          m_valid = 1'b0;
   int          m_cnt = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_pc = 8'd0; m_inst = 32'd0; m_ipc = 8'd0; m_valid = 1'b0; m_cnt = 0;
      end else begin
         bit taken;
         bit room;
         taken = m_valid && inst_ready;
         room  = !m_valid || inst_ready;
         if (taken) begin
            m_valid = 1'b0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
         end
         if (m_phase == 0) begin
            if (redirect_valid) m_pc = redirect_pc;
            if (start) m_phase = 1;
         end else if (m_phase == 1) begin
            if (redirect_valid) begin
               m_pc = redirect_pc;
               m_valid = 1'b0;
               if (halt_req) m_phase = 2;
            end else if (halt_req || int'(m_pc) == 5) begin
               m_phase = 2;
            end else if (room && int'(m_pc) < 5) begin
               m_inst  = rom[m_pc];
               m_ipc   = m_pc;
               m_valid = 1'b1;
               m_pc    = m_pc + 8'd1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("cmp_rom_addr", 32'(rom_addr), 32'(m_pc));
         chk("cmp_inst_valid", 32'(inst_valid), 32'(m_valid));
         chk("cmp_inst", inst, m_inst);
         chk("cmp_inst_pc", 32'(inst_pc), 32'(m_ipc));
         chk("cmp_busy", 32'(busy), 32'(m_phase == 1));
         chk("cmp_halted", 32'(halted), 32'(m_phase == 2));
         chk("cmp_fetch_count", 32'(fetch_count), 32'(m_cnt));
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'd0;
      inst_ready = 1'b0; start_b = 1'b0; ready_b = 1'b0;
      repeat (2) cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      // Straight run to end of program
      do_reset();
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_count", 32'(fetch_count), 32'd0);
      inst_ready = 1'b1;
      pulse_start();
      chk("s1_busy", 32'(busy), 32'd1);
      chk("s1_first_empty", 32'(inst_valid), 32'd0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("s1_valid", 32'(inst_valid), 32'd1);
         chk("s1_inst_pc", 32'(inst_pc), 32'(i));
      end
      chk("s1_inst4", inst, 32'h00222025);
      cyc();
      chk("s1_halted", 32'(halted), 32'd1);
      chk("s1_drained", 32'(inst_valid), 32'd0);
      chk("s1_count", 32'(fetch_count), 32'd5);
      repeat (2) cyc();

      // Back-pressure while inst_pc=1
      do_reset();
      inst_ready = 1'b1;
      pulse_start();
      cyc();
      cyc();
      chk("s2_pc1", 32'(inst_pc), 32'd1);
      inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("s2_hold_inst", inst, 32'h20020009);
         chk("s2_hold_addr", 32'(rom_addr), 32'd2);
         chk("s2_hold_valid", 32'(inst_valid), 32'd1);
      end
      inst_ready = 1'b1;
      for (int i = 2; i < 5; i++) begin
         cyc();
         chk("s2_resume_pc", 32'(inst_pc), 32'(i));
      end
      cyc();
      chk("s2_halted", 32'(halted), 32'd1);
      chk("s2_count", 32'(fetch_count), 32'd5);

      // Redirect to 3 while inst_pc=1 is valid
      do_reset();
      inst_ready = 1'b1;
      pulse_start();
      cyc();
      cyc();
      chk("s3_pc1", 32'(inst_pc), 32'd1);
      redirect_valid = 1'b1; redirect_pc = 8'd3;
      cyc();
      redirect_valid = 1'b0; redirect_pc = 8'd0;
      chk("s3_flushed", 32'(inst_valid), 32'd0);
      chk("s3_rom_addr", 32'(rom_addr), 32'd3);
      cyc();
      chk("s3_target_pc", 32'(inst_pc), 32'd3);
      chk("s3_target_inst", inst, 32'h00221824);
      cyc();
      chk("s3_next_pc", 32'(inst_pc), 32'd4);
      cyc();
      chk("s3_halted", 32'(halted), 32'd1);
      chk("s3_count", 32'(fetch_count), 32'd4);

      // halt_req while inst_pc=2 is valid and stalled
      do_reset();
      inst_ready = 1'b1;
      pulse_start();
      repeat (3) cyc();
      chk("s4_pc2", 32'(inst_pc), 32'd2);
      inst_ready = 1'b0; halt_req = 1'b1;
      cyc();
      chk("s4_halted", 32'(halted), 32'd1);
      chk("s4_pending", 32'(inst_valid), 32'd1);
      chk("s4_inst", inst, 32'h00221020);
      cyc();
      chk("s4_still_pending", 32'(inst_valid), 32'd1);
      inst_ready = 1'b1;
      cyc();
      chk("s4_consumed", 32'(inst_valid), 32'd0);
      chk("s4_count", 32'(fetch_count), 32'd3);
      start = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'd0;
      cyc();
      start = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
      repeat (2) cyc();
      chk("s4_ignore_addr", 32'(rom_addr), 32'd3);
      chk("s4_ignore_halted", 32'(halted), 32'd1);
      chk("s4_final_count", 32'(fetch_count), 32'd3);

      // PC wrap on the PROG_LEN=256 instance
      do_reset();
      chk("s5_reset_pc", 32'(rom_addr_b), 32'd254);
      ready_b = 1'b1;
      start_b = 1'b1;
      cyc();
      start_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] want;
         want = 8'(254 + i);
         cyc();
         chk("s5_wrap_pc", 32'(inst_pc_b), 32'(want));
         chk("s5_wrap_inst", inst_b, rom[want]);
         chk("s5_no_halt", 32'(halted_b), 32'd0);
      end
      chk("s5_busy", 32'(busy_b), 32'd1);
      chk("s5_count", 32'(fetch_count_b), 32'd3);

      // Asynchronous reset mid-run, then redirect while idle
      do_reset();
      inst_ready = 1'b1;
      pulse_start();
      repeat (3) cyc();
      chk("s6_pre_valid", 32'(inst_valid), 32'd1);
      chk("s6_pre_count", 32'(fetch_count), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("s6_async_valid", 32'(inst_valid), 32'd0);
      chk("s6_async_inst", inst, 32'd0);
      chk("s6_async_inst_pc", 32'(inst_pc), 32'd0);
      chk("s6_async_addr", 32'(rom_addr), 32'd0);
      chk("s6_async_busy", 32'(busy), 32'd0);
      chk("s6_async_count", 32'(fetch_count), 32'd0);
      repeat (2) cyc();
      rst = 1'b0;
      repeat (3) cyc();
      chk("s6_idle_valid", 32'(inst_valid), 32'd0);
      chk("s6_idle_busy", 32'(busy), 32'd0);
      redirect_valid = 1'b1; redirect_pc = 8'd2;
      cyc();
      redirect_valid = 1'b0;
      chk("s6_idle_redirect", 32'(rom_addr), 32'd2);
      pulse_start();
      cyc();
      chk("s6_first_pc", 32'(inst_pc), 32'd2);
      chk("s6_first_inst", inst, 32'h00221020);
      repeat (4) cyc();
      chk("s6_halted", 32'(halted), 32'd1);
      chk("s6_count", 32'(fetch_count), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
